xor_stream_decrypter: RTL

//   Receive side of the XOR stream cipher: turns ciphertext bytes back into plaintext.
//   - Keystream is an 8-bit Galois LFSR seeded by a loaded key; it advances once per accepted byte.
//   - Byte k is decrypted as pt = ct ^ ks_k, where ks_0 = key.
//   - Sits between the transport input and the plaintext consumer; ready/valid on both sides.
//   - Exact inverse of the matching encrypter when both sides use the same key and TAPS.

---
 rtl/xor_crypt_pkg.sv | 8 +
 rtl/xor_stream_decrypter_if.sv | 8 +
 rtl/xor_keystream_lfsr.sv | 18 +
 rtl/xor_stream_decrypter.sv | 56 +++++
 4 files changed

// File: rtl/xor_crypt_pkg.sv
// xor_crypt_pkg: keystream taps, LFSR step and FSM states shared by the XOR stream encrypter and decrypter
package xor_crypt_pkg;
  localparam logic [7:0] XOR_TAPS = 8'hB8;
  typedef enum logic {IDLE, RUN} xor_state_t;
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] taps = XOR_TAPS);
    return {1'b0, s[7:1]} ^ (s[0] ? taps : 8'h00);
  endfunction
endpackage

// File: rtl/xor_stream_decrypter_if.sv
// xor_stream_decrypter_if: ready/valid byte stream used on both sides of the decrypter
interface xor_stream_decrypter_if #(parameter int DATA_W = 8);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/xor_keystream_lfsr.sv
// xor_keystream_lfsr: Galois LFSR keystream with seed load and zero-seed guard
module xor_keystream_lfsr
  import xor_crypt_pkg::*;
#(
  parameter logic [7:0] TAPS = XOR_TAPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] ks
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ks <= '0;
    else if (load) ks <= (seed == 8'h00) ? 8'h01 : seed;
    else if (adv) ks <= lfsr_next(ks, TAPS);
endmodule

// File: rtl/xor_stream_decrypter.sv
// xor_stream_decrypter: XOR stream cipher receive side; `define XOR_DEC_COUNT_EN to build the byte_cnt counter
module xor_stream_decrypter
  import xor_crypt_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter logic [7:0] TAPS   = XOR_TAPS,
  parameter int         CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_load,
  input  logic [DATA_W-1:0]     key_in,
  xor_stream_decrypter_if.slave  in_s,
  xor_stream_decrypter_if.master out_m,
  output logic                  keyed,
  output logic [CNT_W-1:0]      byte_cnt
);
  xor_state_t state;
  logic [7:0] ks;
  logic accept;
  // key_load blocks acceptance so the held byte is decrypted with the new seed
  assign in_s.ready = (state == RUN) && !key_load && (!out_m.valid || out_m.ready);
  assign accept = in_s.valid && in_s.ready;
  xor_keystream_lfsr #(.TAPS(TAPS)) u_ks (
    .clk,
    .rst,
    .load(key_load),
    .adv(accept),
    .seed(key_in),
    .ks
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      keyed       <= 1'b0;
      out_m.valid <= 1'b0;
      out_m.data  <= '0;
    end else begin
      if (key_load) begin
        state <= RUN;
        keyed <= 1'b1;
      end
      if (accept) begin
        out_m.data  <= in_s.data ^ ks;
        out_m.valid <= 1'b1;
      end else if (out_m.ready) out_m.valid <= 1'b0;
    end
`ifdef XOR_DEC_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) byte_cnt <= '0;
    else if (key_load) byte_cnt <= '0;
    else if (accept) byte_cnt <= byte_cnt + CNT_W'(1);
`else
  assign byte_cnt = '0;
`endif
endmodule
